// File: rtl/multicycle_control_fsm_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states and datapath select codes.
// Imported by the control FSM, its decoder and the datapath.
package rv32i_ctrl_pkg;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXECUTE = 3'd3,
      ST_MEM = 3'd4, ST_WRITEBACK = 3'd5, ST_TRAP = 3'd6
   } state_e;

   localparam logic [2:0] WB_ALU = 3'b000, WB_MEM = 3'b001, WB_IMM = 3'b010, WB_PC4 = 3'b011;
   localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
   localparam logic [1:0] PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JAL = 2'b10, PC_JALR = 2'b11;
   localparam logic [2:0] MT_WORD = 3'b010;

   typedef struct packed {
      logic [2:0] alu_inst;
      logic       alu_alt;
      logic       alu_in_ctrl;
      logic [2:0] alu_out_ctrl;
      logic [2:0] imm_ctrl;
      logic [2:0] mem_type;
      logic [1:0] ctrl_branch;
      logic       rd1;
      logic       rd2;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
      logic       illegal;
   } ctrl_t;
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;
   logic [31:0] INST;
   logic        MEM_READY, BRANCH_TAKEN;
   logic        IR_WRITE, PC_WRITE, REG_READ_Ctrl_1, REG_READ_Ctrl_2;
   logic        ALU_IN_CTRL, ALU_ALT, Reg_WRITE, read_enable, write_enable;
   logic [2:0]  ALU_INST, ALU_OUT_CTRL, IMM_CTRL, mem_type, STATE;
   logic [1:0]  CTRL_BRANCH;
   logic        ILLEGAL_INST, MEM_TIMEOUT;

   modport master (
      input  INST, MEM_READY, BRANCH_TAKEN,
      output IR_WRITE, PC_WRITE, REG_READ_Ctrl_1, REG_READ_Ctrl_2, ALU_IN_CTRL, ALU_INST,
             ALU_ALT, ALU_OUT_CTRL, IMM_CTRL, Reg_WRITE, read_enable, write_enable,
             mem_type, CTRL_BRANCH, STATE, ILLEGAL_INST, MEM_TIMEOUT
   );
   modport slave (
      output INST, MEM_READY, BRANCH_TAKEN,
      input  IR_WRITE, PC_WRITE, REG_READ_Ctrl_1, REG_READ_Ctrl_2, ALU_IN_CTRL, ALU_INST,
             ALU_ALT, ALU_OUT_CTRL, IMM_CTRL, Reg_WRITE, read_enable, write_enable,
             mem_type, CTRL_BRANCH, STATE, ILLEGAL_INST, MEM_TIMEOUT
   );
endinterface

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational RV32I field decoder: opcode/funct3/funct7[5] to control fields.
module rv32i_inst_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output ctrl_t      ctrl
);
   always_comb begin
      ctrl = '0;
      case (opcode)
         OPC_OP: begin
            ctrl.alu_inst = funct3;
            ctrl.alu_alt  = funct7_b5;
            ctrl.rd1      = 1'b1;
            ctrl.rd2      = 1'b1;
         end
         OPC_OPIMM: begin
            ctrl.alu_inst    = funct3;
            ctrl.alu_in_ctrl = 1'b1;
            ctrl.imm_ctrl    = IMM_I;
            // bit 30 of an I-immediate is only a modifier for the shift-right form
            ctrl.alu_alt     = (funct3 == 3'b101) && funct7_b5;
            ctrl.rd1         = 1'b1;
         end
         OPC_LOAD: begin
            ctrl.alu_in_ctrl  = 1'b1;
            ctrl.imm_ctrl     = IMM_I;
            ctrl.mem_type     = funct3;
            ctrl.alu_out_ctrl = WB_MEM;
            ctrl.rd1          = 1'b1;
            ctrl.is_load      = 1'b1;
         end
         OPC_STORE: begin
            ctrl.alu_in_ctrl = 1'b1;
            ctrl.imm_ctrl    = IMM_S;
            ctrl.mem_type    = funct3;
            ctrl.rd1         = 1'b1;
            ctrl.rd2         = 1'b1;
            ctrl.is_store    = 1'b1;
         end
         OPC_LUI: begin
            ctrl.alu_out_ctrl = WB_IMM;
            ctrl.imm_ctrl     = IMM_U;
         end
         OPC_AUIPC: ctrl.imm_ctrl = IMM_U;
         OPC_JAL: begin
            ctrl.ctrl_branch  = PC_JAL;
            ctrl.alu_out_ctrl = WB_PC4;
            ctrl.imm_ctrl     = IMM_J;
            ctrl.is_jump      = 1'b1;
         end
         OPC_JALR: begin
            ctrl.ctrl_branch  = PC_JALR;
            ctrl.alu_out_ctrl = WB_PC4;
            ctrl.imm_ctrl     = IMM_I;
            ctrl.rd1          = 1'b1;
            ctrl.is_jump      = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.ctrl_branch = PC_BR;
            ctrl.imm_ctrl    = IMM_B;
            ctrl.rd1         = 1'b1;
            ctrl.rd2         = 1'b1;
            ctrl.is_branch   = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: F/D/E/M/WB sequencing, latched decode,
// bounded memory waits and sticky trap causes.
module multicycle_control_fsm
   import rv32i_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter bit ENABLE_TRAP  = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   multicycle_control_fsm_if.master bus
);
   localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [CW-1:0] WAIT_LIM = CW'(MEM_WAIT_MAX);

   state_e        state, nstate;
   logic [6:0]    opc_q;
   logic [2:0]    f3_q;
   logic          f7_q;
   logic [CW-1:0] wait_cnt;
   logic          ill_q, to_q;
   logic          waiting, wait_hit;
   ctrl_t         ctrl;

   // In DECODE the IR is decoded live (illegal check, register reads);
   // afterwards the latched fields hold the controls steady.
   rv32i_inst_decoder u_dec (
      .opcode   ((state == ST_DECODE) ? bus.INST[6:0]   : opc_q),
      .funct3   ((state == ST_DECODE) ? bus.INST[14:12] : f3_q),
      .funct7_b5((state == ST_DECODE) ? bus.INST[30]    : f7_q),
      .ctrl     (ctrl)
   );

   assign waiting  = (state == ST_FETCH) || (state == ST_MEM);
   assign wait_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LIM) && !bus.MEM_READY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE:  nstate = ST_FETCH;
         ST_FETCH: begin
            if (bus.MEM_READY)  nstate = ST_DECODE;
            else if (wait_hit)  nstate = ST_TRAP;
         end
         ST_DECODE: begin
            if (!ctrl.illegal)    nstate = ST_EXECUTE;
            else if (ENABLE_TRAP) nstate = ST_TRAP;
            else                  nstate = ST_FETCH;
         end
         ST_EXECUTE: begin
            if (ctrl.is_load || ctrl.is_store) nstate = ST_MEM;
            else if (ctrl.is_branch)           nstate = ST_FETCH;
            else                               nstate = ST_WRITEBACK;
         end
         ST_MEM: begin
            if (bus.MEM_READY) begin
               if (ctrl.is_load) nstate = ST_WRITEBACK;
               else              nstate = ST_FETCH;
            end else if (wait_hit) nstate = ST_TRAP;
         end
         ST_WRITEBACK: nstate = ST_FETCH;
         ST_TRAP:      nstate = ST_TRAP;
         default:      nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opc_q    <= '0;
         f3_q     <= '0;
         f7_q     <= 1'b0;
         wait_cnt <= '0;
         ill_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         if (state == ST_DECODE) begin
            opc_q <= bus.INST[6:0];
            f3_q  <= bus.INST[14:12];
            f7_q  <= bus.INST[30];
         end
         // Saturating at the limit also keeps a disabled (zero) limit parked at 0.
         if (nstate != state && (nstate == ST_FETCH || nstate == ST_MEM))
            wait_cnt <= '0;
         else if (waiting && !bus.MEM_READY && wait_cnt != WAIT_LIM)
            wait_cnt <= wait_cnt + 1'b1;
         if (state != ST_TRAP && nstate == ST_TRAP) begin
            if (state == ST_DECODE) ill_q <= 1'b1;
            else                    to_q  <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.IR_WRITE        = 1'b0;
      bus.PC_WRITE        = 1'b0;
      bus.REG_READ_Ctrl_1 = 1'b0;
      bus.REG_READ_Ctrl_2 = 1'b0;
      bus.ALU_IN_CTRL     = 1'b0;
      bus.ALU_INST        = 3'b000;
      bus.ALU_ALT         = 1'b0;
      bus.ALU_OUT_CTRL    = WB_ALU;
      bus.IMM_CTRL        = IMM_I;
      bus.Reg_WRITE       = 1'b0;
      bus.read_enable     = 1'b0;
      bus.write_enable    = 1'b0;
      bus.mem_type        = 3'b000;
      bus.CTRL_BRANCH     = PC_SEQ;
      bus.STATE           = state;
      bus.ILLEGAL_INST    = ill_q;
      bus.MEM_TIMEOUT     = to_q;
      case (state)
         ST_FETCH: begin
            bus.read_enable = 1'b1;
            bus.mem_type    = MT_WORD;
            bus.IR_WRITE    = bus.MEM_READY;
            bus.PC_WRITE    = bus.MEM_READY;
         end
         ST_DECODE: begin
            bus.REG_READ_Ctrl_1 = ctrl.rd1;
            bus.REG_READ_Ctrl_2 = ctrl.rd2;
         end
         ST_EXECUTE, ST_MEM, ST_WRITEBACK: begin
            bus.ALU_IN_CTRL  = ctrl.alu_in_ctrl;
            bus.ALU_INST     = ctrl.alu_inst;
            bus.ALU_ALT      = ctrl.alu_alt;
            bus.ALU_OUT_CTRL = ctrl.alu_out_ctrl;
            bus.IMM_CTRL     = ctrl.imm_ctrl;
            bus.mem_type     = ctrl.mem_type;
            bus.CTRL_BRANCH  = ctrl.ctrl_branch;
            if (state == ST_EXECUTE) begin
               bus.REG_READ_Ctrl_1 = ctrl.rd1;
               bus.REG_READ_Ctrl_2 = ctrl.rd2;
               bus.PC_WRITE        = ctrl.is_jump || (ctrl.is_branch && bus.BRANCH_TAKEN);
            end
            if (state == ST_MEM) begin
               bus.read_enable  = ctrl.is_load;
               bus.write_enable = ctrl.is_store;
            end
            if (state == ST_WRITEBACK) bus.Reg_WRITE = 1'b1;
         end
         default: ;
      endcase
   end
endmodule
